// File: rtl/qoi_dma.sv
// Byte-wide DMA engine that halts the 65C02 through RDY and moves blocks between memory regions.
// Optional macro QOI_DMA_IRQ_EN adds a registered completion interrupt on irq_o.
module qoi_dma #(
  parameter int unsigned HALT_WAIT = 2,
  parameter int unsigned BURST_MAX = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        we,
  input  logic [2:0]  addr,
  input  logic [7:0]  data_i,
  output logic [7:0]  data_o,
  output logic        m_sel,
  output logic [15:0] m_addr,
  output logic        m_we,
  output logic [7:0]  m_data_o,
  input  logic [7:0]  m_data_i,
  output logic        rdy_o,
  output logic        irq_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_RD,
    S_CAP,
    S_WR,
    S_GAP,
    S_FIN
  } state_t;

  state_t      state_reg, state_next;
  logic [15:0] src_reg, src_next;
  logic [15:0] dst_reg, dst_next;
  logic [15:0] len_reg, len_next;
  logic        src_inc_reg, src_inc_next;
  logic        dst_inc_reg, dst_inc_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;
  logic        aborted_reg, aborted_next;
  logic        abort_pend_reg, abort_pend_next;
  logic [7:0]  halt_cnt_reg, halt_cnt_next;
  logic [15:0] burst_reg, burst_next;
  logic [7:0]  buf_reg, buf_next;
  logic        rdy_reg, rdy_next;
  logic        m_sel_reg, m_sel_next;

  logic reg_wr;
  logic status_rd;
  logic start_wr;
  logic abort_wr;

  assign reg_wr    = cs & we;
  assign status_rd = cs & ~we & (addr == 3'd7);
  assign start_wr  = reg_wr & (addr == 3'd6) & data_i[0];
  assign abort_wr  = reg_wr & (addr == 3'd6) & data_i[7];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= S_IDLE;
      src_reg        <= 16'd0;
      dst_reg        <= 16'd0;
      len_reg        <= 16'd0;
      src_inc_reg    <= 1'b0;
      dst_inc_reg    <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      aborted_reg    <= 1'b0;
      abort_pend_reg <= 1'b0;
      halt_cnt_reg   <= 8'd0;
      burst_reg      <= 16'd0;
      buf_reg        <= 8'd0;
      rdy_reg        <= 1'b1;
      m_sel_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      src_reg        <= src_next;
      dst_reg        <= dst_next;
      len_reg        <= len_next;
      src_inc_reg    <= src_inc_next;
      dst_inc_reg    <= dst_inc_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
      aborted_reg    <= aborted_next;
      abort_pend_reg <= abort_pend_next;
      halt_cnt_reg   <= halt_cnt_next;
      burst_reg      <= burst_next;
      buf_reg        <= buf_next;
      rdy_reg        <= rdy_next;
      m_sel_reg      <= m_sel_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    src_next        = src_reg;
    dst_next        = dst_reg;
    len_next        = len_reg;
    src_inc_next    = src_inc_reg;
    dst_inc_next    = dst_inc_reg;
    busy_next       = busy_reg;
    done_next       = done_reg;
    aborted_next    = aborted_reg;
    abort_pend_next = abort_pend_reg;
    halt_cnt_next   = halt_cnt_reg;
    burst_next      = burst_reg;
    buf_next        = buf_reg;

    // Programming registers is frozen for the whole transfer so progress is never clobbered.
    if (reg_wr && !busy_reg) begin
      case (addr)
        3'd0: src_next[7:0]  = data_i;
        3'd1: src_next[15:8] = data_i;
        3'd2: dst_next[7:0]  = data_i;
        3'd3: dst_next[15:8] = data_i;
        3'd4: len_next[7:0]  = data_i;
        3'd5: len_next[15:8] = data_i;
        3'd6: begin
          src_inc_next = data_i[1];
          dst_inc_next = data_i[2];
        end
        default: ;
      endcase
    end

    if (status_rd) begin
      done_next    = 1'b0;
      aborted_next = 1'b0;
    end

    case (state_reg)
      S_IDLE: begin
        if (start_wr) begin
          if (len_reg == 16'd0) begin
            done_next = 1'b1;
          end else begin
            busy_next       = 1'b1;
            abort_pend_next = 1'b0;
            halt_cnt_next   = 8'd0;
            burst_next      = 16'd0;
            state_next      = S_HALT;
          end
        end
      end
      S_HALT: begin
        if (abort_wr) begin
          abort_pend_next = 1'b1;
          state_next      = S_FIN;
        end else if ({24'd0, halt_cnt_reg} + 32'd1 >= HALT_WAIT) begin
          state_next = S_RD;
        end else begin
          halt_cnt_next = halt_cnt_reg + 8'd1;
        end
      end
      S_RD: begin
        if (abort_wr) begin
          abort_pend_next = 1'b1;
          state_next      = S_FIN;
        end else begin
          state_next = S_CAP;
        end
      end
      S_CAP: begin
        if (abort_wr) begin
          abort_pend_next = 1'b1;
          state_next      = S_FIN;
        end else begin
          buf_next   = m_data_i;
          state_next = S_WR;
        end
      end
      S_WR: begin
        src_next   = src_reg + {15'd0, src_inc_reg};
        dst_next   = dst_reg + {15'd0, dst_inc_reg};
        len_next   = len_reg - 16'd1;
        burst_next = burst_reg + 16'd1;
        if (abort_wr) begin
          abort_pend_next = 1'b1;
        end
        if (len_reg == 16'd1 || abort_wr) begin
          state_next = S_FIN;
        end else if (BURST_MAX != 0 && {16'd0, burst_reg} + 32'd1 == BURST_MAX) begin
          state_next = S_GAP;
        end else begin
          state_next = S_RD;
        end
      end
      S_GAP: begin
        burst_next = 16'd0;
        if (abort_wr) begin
          abort_pend_next = 1'b1;
          state_next      = S_FIN;
        end else begin
          halt_cnt_next = 8'd0;
          state_next    = S_HALT;
        end
      end
      S_FIN: begin
        busy_next       = 1'b0;
        done_next       = 1'b1;
        aborted_next    = aborted_next | abort_pend_reg;
        abort_pend_next = 1'b0;
        state_next      = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Bus handshake flops follow the next state so they line up exactly with the bus phases.
  always_comb begin
    rdy_next   = !(state_next inside {S_HALT, S_RD, S_CAP, S_WR});
    m_sel_next = state_next inside {S_RD, S_CAP, S_WR};
  end

  assign rdy_o    = rdy_reg;
  assign m_sel    = m_sel_reg;
  assign m_we     = (state_reg == S_WR);
  assign m_addr   = (state_reg == S_RD) ? src_reg : ((state_reg == S_WR) ? dst_reg : 16'd0);
  assign m_data_o = (state_reg == S_WR) ? buf_reg : 8'd0;

  always_comb begin
    data_o = 8'd0;
    case (addr)
      3'd0: data_o = src_reg[7:0];
      3'd1: data_o = src_reg[15:8];
      3'd2: data_o = dst_reg[7:0];
      3'd3: data_o = dst_reg[15:8];
      3'd4: data_o = len_reg[7:0];
      3'd5: data_o = len_reg[15:8];
      3'd6: data_o = {5'd0, dst_inc_reg, src_inc_reg, 1'b0};
      3'd7: data_o = {5'd0, aborted_reg, done_reg, busy_reg};
      default: data_o = 8'd0;
    endcase
  end

`ifdef QOI_DMA_IRQ_EN
  logic irq_reg, irq_next;

  // Raised on every completion event, even if DONE was still pending from an earlier one.
  always_comb begin
    irq_next = irq_reg;
    if (status_rd) begin
      irq_next = 1'b0;
    end
    if (state_reg == S_FIN || (state_reg == S_IDLE && start_wr && len_reg == 16'd0)) begin
      irq_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_reg <= 1'b0;
    end else begin
      irq_reg <= irq_next;
    end
  end

  assign irq_o = irq_reg;
`else
  assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_qoi_dma.sv
// Directed bench for qoi_dma: synchronous memory model on the master port, register-level stimulus.
// Expected irq_o behaviour follows the QOI_DMA_IRQ_EN macro.
module tb_qoi_dma;

  logic        clk;
  logic        rst;
  logic        cs;
  logic        we;
  logic [2:0]  addr;
  logic [7:0]  data_i;
  logic [7:0]  data_o;
  logic        m_sel;
  logic [15:0] m_addr;
  logic        m_we;
  logic [7:0]  m_data_o;
  logic [7:0]  m_data_i;
  logic        rdy_o;
  logic        irq_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  mem [0:65535];
  logic [7:0]  rd_q;
  logic        tb_ld;
  logic [15:0] tb_ld_addr;
  logic [7:0]  tb_ld_data;
  int          wr_total = 0;

  int   rdy_low_total = 0;
  int   msel_total = 0;
  int   overlap_total = 0;
  int   pulse_total = 0;
  logic rdy_h1 = 1'b1;
  logic rdy_h2 = 1'b1;

`ifdef QOI_DMA_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  qoi_dma #(.HALT_WAIT(2), .BURST_MAX(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .cs       (cs),
    .we       (we),
    .addr     (addr),
    .data_i   (data_i),
    .data_o   (data_o),
    .m_sel    (m_sel),
    .m_addr   (m_addr),
    .m_we     (m_we),
    .m_data_o (m_data_o),
    .m_data_i (m_data_i),
    .rdy_o    (rdy_o),
    .irq_o    (irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory: data for the address seen at an edge appears after that edge.
  always @(posedge clk) begin
    if (tb_ld) begin
      mem[tb_ld_addr] <= tb_ld_data;
    end else if (m_sel && m_we) begin
      mem[m_addr] <= m_data_o;
      wr_total    <= wr_total + 1;
    end
    rd_q <= mem[m_addr];
  end
  assign m_data_i = rd_q;

  always @(negedge clk) begin
    if (!rdy_o) rdy_low_total <= rdy_low_total + 1;
    if (m_sel) msel_total <= msel_total + 1;
    if (m_sel && rdy_o) overlap_total <= overlap_total + 1;
    if (rdy_h2 && !rdy_h1 && rdy_o) pulse_total <= pulse_total + 0;
    if (!rdy_h2 && rdy_h1 && !rdy_o) pulse_total <= pulse_total + 1;
    rdy_h2 <= rdy_h1;
    rdy_h1 <= rdy_o;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("check %s: 0x%0h ok", tag, got);
    end
  endtask

  task automatic reg_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; we = 1'b1; addr = a; data_i = d;
    @(negedge clk);
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic reg_read(input logic [2:0] a, output logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; we = 1'b0; addr = a;
    #1 d = data_o;
    @(negedge clk);
    cs = 1'b0;
  endtask

  task automatic mem_load(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    tb_ld = 1'b1; tb_ld_addr = a; tb_ld_data = d;
    @(negedge clk);
    tb_ld = 1'b0;
  endtask

  task automatic setup(input logic [15:0] s, input logic [15:0] dd, input logic [15:0] l);
    reg_write(3'd0, s[7:0]);
    reg_write(3'd1, s[15:8]);
    reg_write(3'd2, dd[7:0]);
    reg_write(3'd3, dd[15:8]);
    reg_write(3'd4, l[7:0]);
    reg_write(3'd5, l[15:8]);
  endtask

  initial begin
    logic [7:0] rv;
    logic [7:0] lo;
    int rdy0, wr0, ms0, pl0, bad;
    logic prev, found;

    rst = 1'b0; cs = 1'b0; we = 1'b0; addr = 3'd0; data_i = 8'd0;
    tb_ld = 1'b0; tb_ld_addr = 16'd0; tb_ld_data = 8'd0;

    // Reset state
    #12;
    check("rst_rdy", rdy_o, 1);
    check("rst_msel", m_sel, 0);
    check("rst_mwe", m_we, 0);
    check("rst_maddr", m_addr, 0);
    check("rst_mdata", m_data_o, 0);
    check("rst_irq", irq_o, 0);
    @(negedge clk);
    rst = 1'b1;
    reg_read(3'd7, rv); check("rst_status", rv, 8'h00);
    reg_read(3'd4, rv); check("rst_len_lo", rv, 8'h00);

    // ABORT while idle does nothing
    reg_write(3'd6, 8'h80);
    reg_read(3'd7, rv); check("idle_abort", rv, 8'h00);

    // IMG -> accel copy of four bytes
    mem_load(16'h8000, 8'h11); mem_load(16'h8001, 8'h22);
    mem_load(16'h8002, 8'h33); mem_load(16'h8003, 8'h44);
    mem_load(16'h0000, 8'hEE);
    setup(16'h8000, 16'hA000, 16'd4);
    rdy0 = rdy_low_total; wr0 = wr_total;
    reg_write(3'd6, 8'h07);
    repeat (30) @(negedge clk);
    check("cp_a000", mem[16'hA000], 8'h11);
    check("cp_a001", mem[16'hA001], 8'h22);
    check("cp_a002", mem[16'hA002], 8'h33);
    check("cp_a003", mem[16'hA003], 8'h44);
    check("cp_rdy_low", rdy_low_total - rdy0, 14);
    check("cp_writes", wr_total - wr0, 4);
    check("cp_irq", irq_o, IRQ_ON);
    reg_read(3'd7, rv); check("cp_status", rv, 8'h02);
    reg_read(3'd7, rv); check("cp_status2", rv, 8'h00);
    check("cp_irq_clr", irq_o, 0);

    // LEN=0 start: DONE only, bus untouched
    reg_write(3'd4, 8'h00); reg_write(3'd5, 8'h00);
    rdy0 = rdy_low_total; ms0 = msel_total;
    reg_write(3'd6, 8'h01);
    reg_read(3'd7, rv); check("len0_status", rv, 8'h02);
    check("len0_rdy", rdy_low_total - rdy0, 0);
    check("len0_msel", msel_total - ms0, 0);
    reg_read(3'd6, rv); check("len0_ctrl", rv, 8'h00);

    // 40-byte copy split into bursts of 16
    for (int i = 0; i < 40; i++) mem_load(16'h8100 + 16'(i), 8'(i * 7 + 3));
    setup(16'h8100, 16'hA100, 16'd40);
    rdy0 = rdy_low_total; wr0 = wr_total; pl0 = pulse_total;
    reg_write(3'd6, 8'h07);
    repeat (160) @(negedge clk);
    bad = 0;
    for (int i = 0; i < 40; i++) if (mem[16'hA100 + 16'(i)] !== 8'(i * 7 + 3)) bad++;
    check("bst_data_bad", bad, 0);
    check("bst_last", mem[16'hA127], 8'(39 * 7 + 3));
    check("bst_gaps", pulse_total - pl0, 2);
    check("bst_rdy_low", rdy_low_total - rdy0, 126);
    check("bst_writes", wr_total - wr0, 40);
    reg_read(3'd7, rv); check("bst_status", rv, 8'h02);

    // Fixed-source fill into QOI region
    mem_load(16'hA3FF, 8'h5C);
    setup(16'hA3FF, 16'h9000, 16'd8);
    reg_write(3'd6, 8'h05);
    repeat (40) @(negedge clk);
    bad = 0;
    for (int i = 0; i < 8; i++) if (mem[16'h9000 + 16'(i)] !== 8'h5C) bad++;
    check("fill_bad", bad, 0);
    reg_read(3'd0, lo); reg_read(3'd1, rv);
    check("fill_src", {rv, lo}, 16'hA3FF);
    reg_read(3'd2, lo); reg_read(3'd3, rv);
    check("fill_dst", {rv, lo}, 16'h9008);
    reg_read(3'd7, rv); check("fill_status", rv, 8'h02);

    // DST wraps past 0xFFFF, then ABORT lands in the first GAP
    setup(16'h8100, 16'hFFF0, 16'd20);
    wr0 = wr_total;
    reg_write(3'd6, 8'h07);
    prev = rdy_o; found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (!prev && rdy_o) found = 1'b1;
      prev = rdy_o;
    end
    check("ab_gap_seen", found, 1);
    if (found) begin
      cs = 1'b1; we = 1'b1; addr = 3'd6; data_i = 8'h80;
      @(negedge clk);
      cs = 1'b0; we = 1'b0;
    end
    repeat (20) @(negedge clk);
    check("ab_writes", wr_total - wr0, 16);
    check("ab_fff0", mem[16'hFFF0], 8'h03);
    check("ab_ffff", mem[16'hFFFF], 8'h6C);
    check("ab_0000", mem[16'h0000], 8'hEE);
    reg_read(3'd2, lo); reg_read(3'd3, rv);
    check("ab_dst", {rv, lo}, 16'h0000);
    reg_read(3'd4, lo); reg_read(3'd5, rv);
    check("ab_len", {rv, lo}, 16'd4);
    reg_read(3'd7, rv); check("ab_status", rv, 8'h06);

    // Single byte: completion interrupt
    setup(16'h8000, 16'hA010, 16'd1);
    reg_write(3'd6, 8'h07);
    repeat (15) @(negedge clk);
    check("irq_set", irq_o, IRQ_ON);
    check("irq_byte", mem[16'hA010], 8'h11);
    reg_read(3'd7, rv); check("irq_status", rv, 8'h02);
    check("irq_clr", irq_o, 0);

    // Reset in the middle of a transfer releases the bus at once
    setup(16'h8100, 16'hB000, 16'd20);
    reg_write(3'd6, 8'h07);
    repeat (5) @(negedge clk);
    check("mid_rdy_low", rdy_o, 0);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_rdy", rdy_o, 1);
    check("mid_rst_msel", m_sel, 0);
    check("mid_rst_mwe", m_we, 0);
    @(negedge clk);
    rst = 1'b1;
    reg_read(3'd7, rv); check("mid_status", rv, 8'h00);
    reg_read(3'd4, rv); check("mid_len_lo", rv, 8'h00);

    check("msel_while_rdy", overlap_total, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/qoi_dma.md
Name: qoi_dma

Overview:
- Byte-wide DMA engine on the 6502 bus. Moves blocks between system memory (IMG 0x8000–0x8FFF, QOI 0x9000–0x9FFF, RAM) and the accelerator memory window (0xA000–0xA3FF) without CPU copy loops.
- Steals the bus by pulling CPU RDY low, then drives address, write enable and data through the top-level bus mux.
- Programmed through an 8-byte register window and released back to the CPU between bursts.

Parameters:
- HALT_WAIT, 2: cycles between rdy_o falling and first bus drive, so the 65C02 finishes its current cycle.
- BURST_MAX, 16: max bytes moved per bus tenure before the bus is returned for at least one cycle; 0 = unlimited.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- cs  in  1  register window select
- we  in  1  CPU write strobe
- addr  in  3  register offset
- data_i  in  8  CPU write data
- data_o  out  8  register read data, combinational from addr
- m_sel  out  1  DMA owns bus; top mux selects m_* over CPU AB/DO/WE
- m_addr  out  16  master address
- m_we  out  1  master write enable
- m_data_o  out  8  master write data
- m_data_i  in  8  master read data; valid the cycle after the address is driven (synchronous memory)
- rdy_o  out  1  CPU RDY; low while DMA requests or owns the bus
- irq_o  out  1  interrupt, see Optional Feature

Behaviour:
- Registers:
  - 0 SRC_LO, 1 SRC_HI, 2 DST_LO, 3 DST_HI, 4 LEN_LO, 5 LEN_HI.
  - 6 CTRL: bit0 START (write-1 pulse, reads 0), bit1 SRC_INC, bit2 DST_INC, bit7 ABORT (write-1 pulse).
  - 7 STATUS: bit0 BUSY, bit1 DONE, bit2 ABORTED. A read of STATUS clears DONE and ABORTED.
- Register writes occur on the cs&we cycle. SRC/DST/LEN writes are ignored while BUSY.
- Reset values (rst low, asynchronous):
  - all registers 0; state IDLE
  - m_sel=0, m_we=0, m_addr=0, m_data_o=0, rdy_o=1, irq_o=0
- State machine:
  - IDLE: START with LEN==0 sets DONE, stays IDLE, never drops rdy_o. START with LEN!=0 sets BUSY, goes to HALT, rdy_o=0.
  - HALT: count HALT_WAIT cycles with rdy_o=0, then go to RD.
  - RD: m_sel=1, m_addr=SRC, m_we=0. Go to CAP.
  - CAP: m_sel=1, latch m_data_i into the byte buffer. Go to WR.
  - WR: m_sel=1, m_addr=DST, m_we=1, m_data_o=buffer.
    - SRC+=SRC_INC, DST+=DST_INC, LEN-=1, burst count +=1.
    - If LEN becomes 0, go to FIN.
    - Else if burst count==BURST_MAX, go to GAP.
    - Else go to RD.
  - GAP: m_sel=0, rdy_o=1 for exactly one cycle, burst count cleared. Go to HALT.
  - FIN: m_sel=0, rdy_o=1, BUSY=0, DONE=1. Go to IDLE.
- Throughput: 3 cycles per byte.
- Arithmetic: SRC/DST are 16-bit and wrap 0xFFFF→0x0000. LEN is 16-bit; LEN=0xFFFF is a legal 65535-byte transfer.
- rdy_o and m_sel are registered outputs. m_sel is never 1 while rdy_o=1.
- ABORT:
  - In HALT/RD/CAP, jump to FIN immediately with no write issued.
  - In WR, the write completes, then go to FIN.
  - ABORTED=1; SRC/DST/LEN keep their progress values.
  - ABORT in IDLE has no effect.
- START while BUSY is ignored.
- A CPU register access can only coincide with a transfer during GAP or HALT (the CPU is halted otherwise); it is honoured normally.
- rst asserted mid-transfer: everything returns to reset values immediately and the bus is released the same cycle.

Optional Feature:
- QOI_DMA_IRQ_EN defined: irq_o is a registered signal that goes 1 on the cycle DONE or ABORTED sets, and clears on a STATUS read or reset.
- QOI_DMA_IRQ_EN undefined: irq_o is tied 0 and the registered logic is absent.

Test Plan:
- Copy from IMG to accel window: SRC=0x8000, DST=0xA000, LEN=4, CTRL=0x07 with image bytes 11 22 33 44 → accel mem 0xA000–0xA003 = 11 22 33 44; rdy_o low for 2+4×3=14 cycles; STATUS=0x02; next read returns 0x00.
- LEN=0, CTRL=0x01 → DONE set next cycle; rdy_o never drops; m_sel never 1.
- Burst split: LEN=40, BURST_MAX=16 → exactly two GAP cycles with rdy_o=1 (after bytes 16 and 32); all 40 bytes correct.
- Fixed-address fill: SRC=0xA3FF, SRC_INC=0, DST=0x9000, LEN=8 → QOI 0x9000–0x9007 all equal the byte at 0xA3FF; SRC reads back 0xA3FF after completion.
- Wrap and abort: DST=0xFFFE, LEN=4, ABORT written during the GAP after byte 2 (BURST_MAX=2) → writes land at 0xFFFE and 0xFFFF only; DST=0x0000, LEN=2, STATUS=0x06.
- IRQ (macro on): complete LEN=1 → irq_o=1 one cycle after FIN; STATUS read → irq_o=0. Mid-transfer rst low → rdy_o=1, m_sel=0 asynchronously.
